// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory responder and its write buffer.
package dmem_pkg;
   localparam int DMEM_ADDR_W   = 10;
   localparam int DMEM_WB_DEPTH = 4;
   localparam int DMEM_CNT_W    = $clog2(DMEM_WB_DEPTH) + 1;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic [DMEM_ADDR_W-1:0] idx;
      logic [31:0]            data;
   } wb_entry_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data port of the memory responder: request, read response and buffer status.
interface dmem_responder_if
   import dmem_pkg::*;
#(
   parameter int WB_DEPTH = DMEM_WB_DEPTH
);
   logic [31:0]                daddr;
   logic [31:0]                data_in;
   logic                       mem_en;
   logic                       rd_en;
   logic [31:0]                mem_data;
   logic                       rd_valid;
   logic                       stall;
   logic [cnt_w(WB_DEPTH)-1:0] wb_count;
   logic                       wb_empty;

   modport master (
      output daddr, data_in, mem_en, rd_en,
      input  mem_data, rd_valid, stall, wb_count, wb_empty
   );
   modport slave (
      input  daddr, data_in, mem_en, rd_en,
      output mem_data, rd_valid, stall, wb_count, wb_empty
   );
endinterface

// File: rtl/dmem_responder_wbuf_fifo.sv
// Posted-write circular buffer with per-entry valid bits and an associative idx lookup.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int WB_DEPTH = DMEM_WB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DMEM_ADDR_W-1:0]     lk_idx,
   input  logic                       wr,
   input  logic [31:0]                wr_data,
   input  logic                       pop,
   output logic                       hit,
   output logic [31:0]                hit_data,
   output wb_entry_t                  head,
   output logic [cnt_w(WB_DEPTH)-1:0] count
);
   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = cnt_w(WB_DEPTH);

   wb_entry_t           ent [WB_DEPTH];
   logic [WB_DEPTH-1:0] vld;
   logic [PTR_W-1:0]    hd, tl, hit_ptr;
   logic [CNT_W-1:0]    cnt;
   logic                coal, push;

   // Coalescing keeps at most one valid entry per idx, so the match is one-hot.
   always_comb begin
      hit     = 1'b0;
      hit_ptr = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (vld[i] && ent[i].idx == lk_idx) begin
            hit     = 1'b1;
            hit_ptr = PTR_W'(i);
         end
      end
   end

   assign hit_data = ent[hit_ptr].data;
   assign head     = ent[hd];
   assign count    = cnt;
   // An entry leaving this cycle cannot absorb new data; re-push it instead.
   assign coal     = wr && hit && !(pop && hit_ptr == hd);
   assign push     = wr && !coal;

   always_ff @(posedge clk) begin
      if (rst) begin
         hd  <= '0;
         tl  <= '0;
         cnt <= '0;
         vld <= '0;
      end else begin
         if (pop) begin
            vld[hd] <= 1'b0;
            hd      <= hd + 1'b1;
         end
         if (push) begin
            vld[tl] <= 1'b1;
            tl      <= tl + 1'b1;
         end
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push)      ent[tl]           <= '{idx: lk_idx, data: wr_data};
      else if (coal) ent[hit_ptr].data <= wr_data;
   end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array behind a posted-write buffer with forwarding and backpressure.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int WB_DEPTH = DMEM_WB_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);
   localparam int CNT_W = cnt_w(WB_DEPTH);

   logic [ADDR_W-1:0] idx;
   logic              hit, stall, rd_acc, wr_acc, rd_miss, pop;
   logic [31:0]       hit_data;
   wb_entry_t         head;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       mem_data_q;
   logic              rd_valid_q;
   logic [31:0]       mem [2**ADDR_W];
   logic              unused_addr;

   assign idx         = bus.daddr[ADDR_W+1:2];
   assign unused_addr = ^{bus.daddr[31:ADDR_W+2], bus.daddr[1:0]};

   assign stall   = (cnt == CNT_W'(WB_DEPTH));
   assign rd_acc  = bus.rd_en && !stall;
   assign wr_acc  = bus.mem_en && !stall;
   assign rd_miss = rd_acc && !hit;
   // A read that misses the buffer owns the single array port; otherwise drain.
   assign pop     = (cnt != '0) && !rd_miss;

   wbuf_fifo #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
      .clk      (clk),
      .rst      (rst),
      .lk_idx   (idx),
      .wr       (wr_acc),
      .wr_data  (bus.data_in),
      .pop      (pop),
      .hit      (hit),
      .hit_data (hit_data),
      .head     (head),
      .count    (cnt)
   );

   always_ff @(posedge clk) begin
      if (pop && !rst) mem[head.idx] <= head.data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_data_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) mem_data_q <= hit ? hit_data : mem[idx];
      end
   end

   assign bus.mem_data = mem_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.stall    = stall;
   assign bus.wb_count = cnt;
   assign bus.wb_empty = (cnt == '0);
endmodule
